dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the 256-byte data memory.
- Port 0 is the CPU MEM stage; port 1 is the debug/program loader.
- Each port uses a valid/ready request channel and a valid/ready response channel.
- The block round-robins requests onto the single memory port, registers each command for one cycle while it drives the memory, and returns a response carrying read data or an error.
- Misaligned or illegal accesses are rejected without touching memory.

Parameters:
- ADDR_W, 8, byte address width (memory depth 2^ADDR_W bytes).
- DATA_W, 32, data width; fixed at 32 for the access-type encoding.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- pN_req_valid  in  1  request valid (N = 0, 1 for every pN_ port below).
- pN_req_ready  out  1  request accepted this cycle when valid&&ready.
- pN_req_we  in  1  1 = store, 0 = load.
- pN_req_addr  in  ADDR_W  byte address.
- pN_req_wdata  in  32  store data, low bits used for SB/SH.
- pN_req_type  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- pN_rsp_valid  out  1  response valid.
- pN_rsp_ready  in  1  response consumed.
- pN_rsp_rdata  out  32  load data; 0 for stores and errors.
- pN_rsp_err  out  1  access rejected (misaligned or illegal type).
- mem_wr  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  32  memory write data.
- mem_type  out  3  memory access type.
- mem_dout  in  32  memory combinational read data.

Behaviour:
- Reset (async on rstn low, released synchronously to clk):
  - cmd_valid=0, rsp_valid=0, last_grant=1, so port 0 wins the first contention.
  - All pN_req_ready, pN_rsp_valid, pN_rsp_err and mem_wr are 0.
  - pN_rsp_rdata, mem_addr, mem_din and mem_type are 0.
- Pipeline has three stages:
  - A: arbitrate/accept.
  - C: command register, which drives the memory.
  - R: response register.
- rsp_load = cmd_valid && (!rsp_valid || owner_rsp_ready), where owner_rsp_ready is the rsp_ready of the port owning the R register.
- cmd_free = !cmd_valid || rsp_load.
- Arbitration:
  - Only one port valid: that port is granted.
  - Both ports valid: the port != last_grant is granted.
  - pN_req_ready = granted(N) && cmd_free. It is combinational on valid, so at most one ready is high per cycle.
- On accept:
  - C loads {owner, we, addr, wdata, type}; cmd_valid=1; last_grant=owner.
  - When cmd_free and nothing is accepted, cmd_valid goes to 0.
- C stage:
  - mem_addr, mem_din and mem_type are driven from C whenever cmd_valid; they hold their last value otherwise.
  - err_c = illegal type (011, 110, 111), or H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - mem_wr = cmd_valid && we && !err_c && rsp_load. Gating with rsp_load guarantees exactly one write per accepted store, even under response stall.
- R stage, on rsp_load:
  - Captures owner and err=err_c.
  - rdata = (!we && !err_c) ? mem_dout : 0.
  - rsp_valid=1.
  - When rsp_valid && owner_rsp_ready && !cmd_valid, rsp_valid goes to 0.
- Routing:
  - pN_rsp_valid = rsp_valid && owner==N.
  - rdata and err are routed only to the owner; the other port sees 0.
- Latency and throughput:
  - Accept at edge k gives response valid after edge k+1 (1-cycle latency from accept to rsp_valid).
  - Throughput is 1 access/cycle with no stalls.
  - Responses complete in strict acceptance order.
- Back-pressure: while the R owner holds rsp_ready=0 and C is full, both req_ready signals are 0 and C holds unchanged (no write issued).
- Requester rule: a requester must hold its request stable while valid && !ready. The arbiter may switch grant if the other port becomes valid, because last_grant only updates on accept.
- Addresses near top: W at addr 0xFC is legal. Aligned accesses never wrap past 0xFF, so no wrap handling is needed.
- Mid-operation reset: drops cmd/rsp immediately. A pending store is not written unless its write edge already occurred.

Decomposition:
- Shared package dm_pkg holds:
  - MEM_BYTE=000, MEM_HALF=001, MEM_WORD=010, MEM_BYTE_U=100, MEM_HALF_U=101.
  - Function mem_misaligned(type, addr[1:0]) returning the error condition; it is also reused by the CPU exception logic.
- One natural sub-module: dm_rr_arb2, the 2-way round-robin grant with last_grant register.
- Pipeline registers stay in dm_arbiter.

Test Plan:
1. Reset, then p0 SW addr 0x10 wdata 0xDEADBEEF, then p0 LW 0x10 → mem_wr pulses once; load response rdata=0xDEADBEEF, err=0, one cycle after accept.
2. p0 and p1 both hold LBU requests to 0x10/0x13 for 4 cycles:
   - Grants alternate p0,p1,p0,p1.
   - Responses return in order: p0 rdata=0xEF, p1 rdata=0xDE.
3. p1 SH addr 0x21 data 0x1234 → rsp_err=1, rdata=0, mem_wr never asserts. A subsequent LW 0x20 returns 0x00000000.
4. p0 SB 0x30 data 0x80 accepted while p0_rsp_ready=0 for 5 cycles:
   - req_ready stays 0 for p1 while the pipe is full.
   - mem_wr asserts exactly once after rsp_ready rises.
   - LB 0x30 then returns 0xFFFFFF80; LBU 0x30 returns 0x00000080.
5. p0 SW 0x40 accepted, rstn pulsed low before rsp_ready → all outputs 0 immediately. After release, p0 wins the first p0/p1 contention.
6. Back-to-back p0 stores to 0x00..0x0C with rsp_ready=1 → one accept per cycle. LW 0xFC (legal), LH 0xFF (err), type 3'b111 (err).

Source files
------------

// File: rtl/dm_pkg.sv
// Data-memory access-type encodings and the shared alignment/legality check.
// Also used by the CPU exception logic, so keep mem_misaligned free of side effects.
package dm_pkg;

    localparam int unsigned MEM_TYPE_W = 3;

    typedef enum logic [MEM_TYPE_W-1:0] {
        MEM_BYTE   = 3'b000,
        MEM_HALF   = 3'b001,
        MEM_WORD   = 3'b010,
        MEM_BYTE_U = 3'b100,
        MEM_HALF_U = 3'b101
    } mem_type_e;

    // True for an illegal type encoding or an access not aligned to its size.
    function automatic logic mem_misaligned(input logic [MEM_TYPE_W-1:0] typ,
                                            input logic [1:0]            addr_lo);
        logic bad;
        case (typ)
            MEM_BYTE, MEM_BYTE_U: bad = 1'b0;
            MEM_HALF, MEM_HALF_U: bad = addr_lo[0];
            MEM_WORD:             bad = (addr_lo != 2'b00);
            default:              bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester-side request/response channel pair for the data-memory arbiter.
// master = requester (CPU MEM stage or loader), slave = arbiter.
interface dm_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    import dm_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [MEM_TYPE_W-1:0] req_type;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_type, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_type, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dm_rr_arb2.sv
// Two-way round-robin grant; combinational grant, 0-cycle latency.
// last_grant only moves on an actual accept, so a stalled grant may switch ports.
module dm_rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic last_grant_q;
    logic last_grant_d;
    logic gnt_idx;

    always_comb begin
        gnt_idx      = req[1];
        gnt          = 2'b00;
        last_grant_d = last_grant_q;
        if (req[0] && req[1]) begin
            gnt_idx = ~last_grant_q;
        end
        if (req != 2'b00) begin
            gnt = gnt_idx ? 2'b10 : 2'b01;
        end
        if (accept) begin
            last_grant_d = gnt_idx;
        end
    end

    // Reset to port 1 so port 0 wins the first contention.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer in front of the byte-addressed data memory.
// Latency: accept -> command reg (drives memory) -> response reg; rsp_valid one cycle after accept.
// Backpressure: a stalled response owner freezes the command reg and drops both req_ready.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    dm_arbiter_if.slave           p0,
    dm_arbiter_if.slave           p1,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_din,
    output logic [MEM_TYPE_W-1:0] mem_type,
    input  logic [DATA_W-1:0]     mem_dout
);

    logic                  cmd_valid_q, cmd_valid_d;
    logic                  cmd_owner_q, cmd_owner_d;
    logic                  cmd_we_q,    cmd_we_d;
    logic [ADDR_W-1:0]     cmd_addr_q,  cmd_addr_d;
    logic [DATA_W-1:0]     cmd_wdata_q, cmd_wdata_d;
    logic [MEM_TYPE_W-1:0] cmd_type_q,  cmd_type_d;

    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_owner_q, rsp_owner_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       accept;
    logic       owner_rsp_ready;
    logic       rsp_load;
    logic       cmd_free;
    logic       err_c;
    logic       rsp_sel0;
    logic       rsp_sel1;

    assign req = {p1.req_valid, p0.req_valid};

    dm_rr_arb2 u_arb (
        .clk    (clk),
        .rstn   (rstn),
        .req    (req),
        .accept (accept),
        .gnt    (gnt)
    );

    assign owner_rsp_ready = rsp_owner_q ? p1.rsp_ready : p0.rsp_ready;
    assign rsp_load        = cmd_valid_q && (!rsp_valid_q || owner_rsp_ready);
    assign cmd_free        = !cmd_valid_q || rsp_load;
    assign accept          = (gnt != 2'b00) && cmd_free;

    assign p0.req_ready = gnt[0] && cmd_free;
    assign p1.req_ready = gnt[1] && cmd_free;

    assign err_c = mem_misaligned(cmd_type_q, cmd_addr_q[1:0]);

    // The write fires on the same edge the command moves into R, so a
    // stalled response can never cause a store to be issued twice.
    assign mem_wr   = cmd_valid_q && cmd_we_q && !err_c && rsp_load;
    assign mem_addr = cmd_addr_q;
    assign mem_din  = cmd_wdata_q;
    assign mem_type = cmd_type_q;

    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_owner_d = cmd_owner_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_type_d  = cmd_type_q;
        rsp_valid_d = rsp_valid_q;
        rsp_owner_d = rsp_owner_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        if (accept) begin
            cmd_valid_d = 1'b1;
            cmd_owner_d = gnt[1];
            cmd_we_d    = gnt[1] ? p1.req_we    : p0.req_we;
            cmd_addr_d  = gnt[1] ? p1.req_addr  : p0.req_addr;
            cmd_wdata_d = gnt[1] ? p1.req_wdata : p0.req_wdata;
            cmd_type_d  = gnt[1] ? p1.req_type  : p0.req_type;
        end else if (cmd_free) begin
            cmd_valid_d = 1'b0;
        end

        if (rsp_load) begin
            rsp_valid_d = 1'b1;
            rsp_owner_d = cmd_owner_q;
            rsp_err_d   = err_c;
            rsp_rdata_d = (!cmd_we_q && !err_c) ? mem_dout : '0;
        end else if (rsp_valid_q && owner_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_valid_q <= 1'b0;
            cmd_owner_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_type_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_owner_q <= cmd_owner_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_type_q  <= cmd_type_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Response data and error are visible only to the owning port.
    assign rsp_sel0     = rsp_valid_q && !rsp_owner_q;
    assign rsp_sel1     = rsp_valid_q &&  rsp_owner_q;
    assign p0.rsp_valid = rsp_sel0;
    assign p1.rsp_valid = rsp_sel1;
    assign p0.rsp_rdata = rsp_sel0 ? rsp_rdata_q : '0;
    assign p1.rsp_rdata = rsp_sel1 ? rsp_rdata_q : '0;
    assign p0.rsp_err   = rsp_sel0 && rsp_err_q;
    assign p1.rsp_err   = rsp_sel1 && rsp_err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a little-endian 256-byte memory model behind it.
module tb_dm_arbiter;
    import dm_pkg::*;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        mem_wr;
    logic [7:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic [2:0]  mem_type;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int w0;

    always #5 clk = ~clk;

    dm_arbiter_if #(.ADDR_W(8), .DATA_W(32)) p0_if ();
    dm_arbiter_if #(.ADDR_W(8), .DATA_W(32)) p1_if ();

    dm_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .p0       (p0_if),
        .p1       (p1_if),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_type (mem_type),
        .mem_dout (mem_dout)
    );

    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] ma1, ma2, ma3;
    assign ma1 = mem_addr + 8'd1;
    assign ma2 = mem_addr + 8'd2;
    assign ma3 = mem_addr + 8'd3;

    always_comb begin
        mem_dout = 32'h0;
        case (mem_type)
            3'b000: mem_dout = {{24{mem[mem_addr][7]}}, mem[mem_addr]};
            3'b100: mem_dout = {24'h0, mem[mem_addr]};
            3'b001: mem_dout = {{16{mem[ma1][7]}}, mem[ma1], mem[mem_addr]};
            3'b101: mem_dout = {16'h0, mem[ma1], mem[mem_addr]};
            3'b010: mem_dout = {mem[ma3], mem[ma2], mem[ma1], mem[mem_addr]};
            default: mem_dout = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_wr) begin
            wr_count <= wr_count + 1;
            mem[mem_addr] <= mem_din[7:0];
            if (mem_type[1:0] != 2'b00) mem[ma1] <= mem_din[15:8];
            if (mem_type[1:0] == 2'b10) begin
                mem[ma2] <= mem_din[23:16];
                mem[ma3] <= mem_din[31:24];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_if.req_valid = 1'b0; p0_if.req_we = 1'b0; p0_if.req_addr = 8'h0;
        p0_if.req_wdata = 32'h0; p0_if.req_type = 3'b0; p0_if.rsp_ready = 1'b1;
        p1_if.req_valid = 1'b0; p1_if.req_we = 1'b0; p1_if.req_addr = 8'h0;
        p1_if.req_wdata = 32'h0; p1_if.req_type = 3'b0; p1_if.rsp_ready = 1'b1;
    endtask

    task automatic drive(input int port, input logic we, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [2:0] typ);
        if (port == 0) begin
            p0_if.req_valid = 1'b1; p0_if.req_we = we; p0_if.req_addr = addr;
            p0_if.req_wdata = wdata; p0_if.req_type = typ;
        end else begin
            p1_if.req_valid = 1'b1; p1_if.req_we = we; p1_if.req_addr = addr;
            p1_if.req_wdata = wdata; p1_if.req_type = typ;
        end
    endtask

    task automatic release_req(input int port);
        if (port == 0) p0_if.req_valid = 1'b0;
        else           p1_if.req_valid = 1'b0;
    endtask

    // Issue one request, let it be accepted, and stop just after its response is registered.
    task automatic single(input int port, input logic we, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [2:0] typ);
        drive(port, we, addr, wdata, typ);
        tick();
        release_req(port);
        tick();
    endtask

    task automatic test_reset();
        idle();
        rstn = 1'b0;
        tick(); tick();
        checks++; if (p0_if.req_ready !== 1'b0) begin errors++; $display("FAIL rst_p0_ready got %b exp 0", p0_if.req_ready); end
        checks++; if (p1_if.req_ready !== 1'b0) begin errors++; $display("FAIL rst_p1_ready got %b exp 0", p1_if.req_ready); end
        checks++; if (p0_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_p0_rsp_valid got %b exp 0", p0_if.rsp_valid); end
        checks++; if (p1_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_p1_rsp_valid got %b exp 0", p1_if.rsp_valid); end
        checks++; if (p0_if.rsp_err !== 1'b0 || p1_if.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b%b exp 00", p1_if.rsp_err, p0_if.rsp_err); end
        checks++; if (p0_if.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", p0_if.rsp_rdata); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_mem_wr got %b exp 0", mem_wr); end
        checks++; if (mem_addr !== 8'h0 || mem_din !== 32'h0 || mem_type !== 3'b0) begin errors++; $display("FAIL rst_mem_bus got %h/%h/%b exp 0/0/0", mem_addr, mem_din, mem_type); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_store_load();
        w0 = wr_count;
        drive(0, 1'b1, 8'h10, 32'hDEADBEEF, MEM_WORD);
        #1;
        checks++; if (p0_if.req_ready !== 1'b1) begin errors++; $display("FAIL sl_ready got %b exp 1", p0_if.req_ready); end
        tick();
        release_req(0);
        #1;
        checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL sl_mem_wr got %b exp 1", mem_wr); end
        checks++; if (mem_addr !== 8'h10 || mem_din !== 32'hDEADBEEF) begin errors++; $display("FAIL sl_mem_bus got %h/%h exp 10/deadbeef", mem_addr, mem_din); end
        checks++; if (p0_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL sl_early_rsp got %b exp 0", p0_if.rsp_valid); end
        tick();
        checks++; if (p0_if.rsp_valid !== 1'b1 || p0_if.rsp_rdata !== 32'h0 || p0_if.rsp_err !== 1'b0) begin errors++; $display("FAIL sl_st_rsp got v%b d%h e%b exp v1 d0 e0", p0_if.rsp_valid, p0_if.rsp_rdata, p0_if.rsp_err); end
        checks++; if (wr_count !== w0 + 1) begin errors++; $display("FAIL sl_wr_count got %0d exp %0d", wr_count, w0 + 1); end
        single(0, 1'b0, 8'h10, 32'h0, MEM_WORD);
        checks++; if (p0_if.rsp_valid !== 1'b1 || p0_if.rsp_rdata !== 32'hDEADBEEF || p0_if.rsp_err !== 1'b0) begin errors++; $display("FAIL sl_ld_rsp got v%b d%h e%b exp v1 deadbeef e0", p0_if.rsp_valid, p0_if.rsp_rdata, p0_if.rsp_err); end
        checks++; if (wr_count !== w0 + 1) begin errors++; $display("FAIL sl_wr_once got %0d exp %0d", wr_count, w0 + 1); end
    endtask

    task automatic test_rr_alternate();
        logic exp0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                drive(0, 1'b0, 8'h10, 32'h0, MEM_BYTE_U);
                drive(1, 1'b0, 8'h13, 32'h0, MEM_BYTE_U);
            end else begin
                release_req(0);
                release_req(1);
            end
            #1;
            exp0 = (i % 2 == 0);
            if (i < 4) begin
                checks++; if (p0_if.req_ready !== exp0 || p1_if.req_ready !== !exp0) begin errors++; $display("FAIL rr_grant%0d got %b%b exp %b%b", i, p1_if.req_ready, p0_if.req_ready, !exp0, exp0); end
            end
            if (i >= 2 && exp0) begin
                checks++; if (p0_if.rsp_valid !== 1'b1 || p0_if.rsp_rdata !== 32'hEF || p1_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_rsp%0d got p0 v%b d%h p1 v%b exp v1 ef v0", i, p0_if.rsp_valid, p0_if.rsp_rdata, p1_if.rsp_valid); end
            end
            if (i >= 2 && !exp0) begin
                checks++; if (p1_if.rsp_valid !== 1'b1 || p1_if.rsp_rdata !== 32'hDE || p0_if.rsp_valid !== 1'b0 || p0_if.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rr_rsp%0d got p1 v%b d%h p0 v%b d%h exp v1 de v0 0", i, p1_if.rsp_valid, p1_if.rsp_rdata, p0_if.rsp_valid, p0_if.rsp_rdata); end
            end
            tick();
        end
    endtask

    task automatic test_misaligned();
        w0 = wr_count;
        drive(1, 1'b1, 8'h21, 32'h1234, MEM_HALF);
        #1;
        checks++; if (p1_if.req_ready !== 1'b1) begin errors++; $display("FAIL mis_ready got %b exp 1", p1_if.req_ready); end
        tick();
        release_req(1);
        #1;
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL mis_mem_wr got %b exp 0", mem_wr); end
        tick();
        checks++; if (p1_if.rsp_valid !== 1'b1 || p1_if.rsp_err !== 1'b1 || p1_if.rsp_rdata !== 32'h0) begin errors++; $display("FAIL mis_rsp got v%b e%b d%h exp v1 e1 d0", p1_if.rsp_valid, p1_if.rsp_err, p1_if.rsp_rdata); end
        checks++; if (p0_if.rsp_err !== 1'b0) begin errors++; $display("FAIL mis_p0_err got %b exp 0", p0_if.rsp_err); end
        single(1, 1'b0, 8'h20, 32'h0, MEM_WORD);
        checks++; if (p1_if.rsp_valid !== 1'b1 || p1_if.rsp_rdata !== 32'h0 || p1_if.rsp_err !== 1'b0) begin errors++; $display("FAIL mis_lw20 got v%b d%h e%b exp v1 0 e0", p1_if.rsp_valid, p1_if.rsp_rdata, p1_if.rsp_err); end
        checks++; if (wr_count !== w0) begin errors++; $display("FAIL mis_no_write got %0d exp %0d", wr_count, w0); end
    endtask

    task automatic test_stall();
        w0 = wr_count;
        p0_if.rsp_ready = 1'b0;
        drive(0, 1'b0, 8'h10, 32'h0, MEM_BYTE_U);
        tick();
        drive(0, 1'b1, 8'h30, 32'h80, MEM_BYTE);
        #1;
        checks++; if (p0_if.req_ready !== 1'b1) begin errors++; $display("FAIL st_b2b_ready got %b exp 1", p0_if.req_ready); end
        tick();
        release_req(0);
        drive(1, 1'b0, 8'h10, 32'h0, MEM_WORD);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (p1_if.req_ready !== 1'b0 || p0_if.req_ready !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL st_hold%0d got rdy %b%b wr %b exp 00 0", i, p1_if.req_ready, p0_if.req_ready, mem_wr); end
            checks++; if (p0_if.rsp_valid !== 1'b1 || p0_if.rsp_rdata !== 32'hEF) begin errors++; $display("FAIL st_held_rsp%0d got v%b d%h exp v1 ef", i, p0_if.rsp_valid, p0_if.rsp_rdata); end
            tick();
        end
        p0_if.rsp_ready = 1'b1;
        #1;
        checks++; if (mem_wr !== 1'b1 || p1_if.req_ready !== 1'b1) begin errors++; $display("FAIL st_release got wr %b p1rdy %b exp 1 1", mem_wr, p1_if.req_ready); end
        tick();
        release_req(1);
        #1;
        checks++; if (p0_if.rsp_valid !== 1'b1 || p0_if.rsp_rdata !== 32'h0 || p0_if.rsp_err !== 1'b0) begin errors++; $display("FAIL st_sb_rsp got v%b d%h e%b exp v1 0 e0", p0_if.rsp_valid, p0_if.rsp_rdata, p0_if.rsp_err); end
        checks++; if (wr_count !== w0 + 1) begin errors++; $display("FAIL st_one_write got %0d exp %0d", wr_count, w0 + 1); end
        tick();
        checks++; if (p1_if.rsp_valid !== 1'b1 || p1_if.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL st_p1_rsp got v%b d%h exp v1 deadbeef", p1_if.rsp_valid, p1_if.rsp_rdata); end
        single(0, 1'b0, 8'h30, 32'h0, MEM_BYTE);
        checks++; if (p0_if.rsp_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL st_lb got %h exp ffffff80", p0_if.rsp_rdata); end
        single(0, 1'b0, 8'h30, 32'h0, MEM_BYTE_U);
        checks++; if (p0_if.rsp_rdata !== 32'h00000080) begin errors++; $display("FAIL st_lbu got %h exp 00000080", p0_if.rsp_rdata); end
        checks++; if (wr_count !== w0 + 1) begin errors++; $display("FAIL st_total_writes got %0d exp %0d", wr_count, w0 + 1); end
    endtask

    task automatic test_mid_reset();
        w0 = wr_count;
        drive(0, 1'b1, 8'h40, 32'h11223344, MEM_WORD);
        tick();
        release_req(0);
        p0_if.rsp_ready = 1'b0;
        #1;
        checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL mr_pending_wr got %b exp 1", mem_wr); end
        rstn = 1'b0;
        #1;
        checks++; if (mem_wr !== 1'b0 || mem_addr !== 8'h0 || mem_din !== 32'h0 || mem_type !== 3'b0) begin errors++; $display("FAIL mr_mem_bus got wr %b %h/%h/%b exp 0 0/0/0", mem_wr, mem_addr, mem_din, mem_type); end
        checks++; if (p0_if.rsp_valid !== 1'b0 || p0_if.req_ready !== 1'b0) begin errors++; $display("FAIL mr_port got v%b rdy %b exp 0 0", p0_if.rsp_valid, p0_if.req_ready); end
        tick();
        rstn = 1'b1;
        idle();
        checks++; if (wr_count !== w0) begin errors++; $display("FAIL mr_no_write got %0d exp %0d", wr_count, w0); end
        drive(0, 1'b0, 8'h10, 32'h0, MEM_WORD);
        drive(1, 1'b0, 8'h20, 32'h0, MEM_WORD);
        #1;
        checks++; if (p0_if.req_ready !== 1'b1 || p1_if.req_ready !== 1'b0) begin errors++; $display("FAIL mr_first_grant got %b%b exp 01", p1_if.req_ready, p0_if.req_ready); end
        tick();
        release_req(0);
        #1;
        checks++; if (p1_if.req_ready !== 1'b1) begin errors++; $display("FAIL mr_second_grant got %b exp 1", p1_if.req_ready); end
        tick();
        release_req(1);
        tick();
        tick();
        single(0, 1'b0, 8'h40, 32'h0, MEM_WORD);
        checks++; if (p0_if.rsp_rdata !== 32'h0) begin errors++; $display("FAIL mr_lw40 got %h exp 0", p0_if.rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        w0 = wr_count;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(0, 1'b1, 8'(i * 4), 32'hA5000000 | 32'(i), MEM_WORD);
            else       release_req(0);
            #1;
            if (i < 4) begin
                checks++; if (p0_if.req_ready !== 1'b1) begin errors++; $display("FAIL bb_ready%0d got %b exp 1", i, p0_if.req_ready); end
            end
            if (i >= 1) begin
                checks++; if (mem_wr !== 1'b1 || mem_addr !== 8'((i - 1) * 4)) begin errors++; $display("FAIL bb_wr%0d got wr %b a %h exp 1 %h", i, mem_wr, mem_addr, 8'((i - 1) * 4)); end
            end
            tick();
        end
        tick();
        checks++; if (wr_count !== w0 + 4) begin errors++; $display("FAIL bb_writes got %0d exp %0d", wr_count, w0 + 4); end
        single(0, 1'b0, 8'h08, 32'h0, MEM_WORD);
        checks++; if (p0_if.rsp_rdata !== 32'hA5000002) begin errors++; $display("FAIL bb_lw08 got %h exp a5000002", p0_if.rsp_rdata); end
        single(0, 1'b1, 8'hFC, 32'hCAFEF00D, MEM_WORD);
        checks++; if (p0_if.rsp_err !== 1'b0) begin errors++; $display("FAIL bb_sw_fc_err got %b exp 0", p0_if.rsp_err); end
        single(0, 1'b0, 8'hFC, 32'h0, MEM_WORD);
        checks++; if (p0_if.rsp_rdata !== 32'hCAFEF00D || p0_if.rsp_err !== 1'b0) begin errors++; $display("FAIL bb_lw_fc got d%h e%b exp cafef00d e0", p0_if.rsp_rdata, p0_if.rsp_err); end
        single(0, 1'b0, 8'hFF, 32'h0, MEM_HALF);
        checks++; if (p0_if.rsp_err !== 1'b1 || p0_if.rsp_rdata !== 32'h0) begin errors++; $display("FAIL bb_lh_ff got e%b d%h exp e1 0", p0_if.rsp_err, p0_if.rsp_rdata); end
        single(0, 1'b0, 8'h00, 32'h0, 3'b111);
        checks++; if (p0_if.rsp_err !== 1'b1 || p0_if.rsp_rdata !== 32'h0) begin errors++; $display("FAIL bb_type7 got e%b d%h exp e1 0", p0_if.rsp_err, p0_if.rsp_rdata); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_rr_alternate();
        test_misaligned();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
